flash_remap_table: RTL and testbench

- Logical-to-physical page remapping table and free-page allocator feeding the flash interface controller.
- Hands out the next free physical page on get_next_addr.
- On update_enable, commits a logical page to the most recently allocated physical page, frees the superseded page, and pulses update_done.
- Serves one-cycle registered lookups for the read path.

---
 rtl/flash_remap_table_if.sv | 37 +++
 rtl/flash_remap_table.sv | 117 +++++++++++
 tb/tb_flash_remap_table.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/flash_remap_table_if.sv
// flash_remap_table_if: allocator, commit and lookup signals of flash_remap_table; trim pins exist only with REMAP_TRIM_EN.
interface flash_remap_table_if #(
    parameter int LADDR_W = 6,
    parameter int PADDR_W = 8
);
    logic               get_next_addr;
    logic [PADDR_W-1:0] addr;
    logic               addr_valid;
    logic               update_enable;
    logic [LADDR_W-1:0] update_laddr;
    logic               update_done;
    logic               lookup_en;
    logic [LADDR_W-1:0] lookup_laddr;
    logic [PADDR_W-1:0] lookup_paddr;
    logic               lookup_hit;
    logic               lookup_ack;
    logic               table_full;
    logic [PADDR_W:0]   free_count;
`ifdef REMAP_TRIM_EN
    logic               trim_enable;
    logic [LADDR_W-1:0] trim_laddr;
`endif
    modport master (
        output get_next_addr, update_enable, update_laddr, lookup_en, lookup_laddr,
`ifdef REMAP_TRIM_EN
        output trim_enable, trim_laddr,
`endif
        input  addr, addr_valid, update_done, lookup_paddr, lookup_hit, lookup_ack, table_full, free_count
    );
    modport slave (
        input  get_next_addr, update_enable, update_laddr, lookup_en, lookup_laddr,
`ifdef REMAP_TRIM_EN
        input  trim_enable, trim_laddr,
`endif
        output addr, addr_valid, update_done, lookup_paddr, lookup_hit, lookup_ack, table_full, free_count
    );
endinterface

// File: rtl/flash_remap_table.sv
// flash_remap_table: logical-to-physical page map with a one-page-per-cycle free-page scanner; define REMAP_TRIM_EN to add trim.
module flash_remap_table #(
    parameter int LADDR_W = 6,
    parameter int PADDR_W = 8
) (
    input  logic CLK,
    input  logic nRST,
    flash_remap_table_if.slave bus
);
    localparam int NLOG  = 1 << LADDR_W;
    localparam int NPHYS = 1 << PADDR_W;

    typedef enum logic [1:0] {SCAN, READY, FULL} state_t;

    state_t             state, state_nxt;
    logic [PADDR_W-1:0] map_paddr [NLOG];
    logic [NLOG-1:0]    map_valid;
    logic [NPHYS-1:0]   used, used_nxt;
    logic [PADDR_W-1:0] ptr, scan_cnt, pending_paddr;
    logic               pending_valid;
    logic [PADDR_W:0]   free_count, free_count_nxt;
    logic               get_fire, upd_fire, upd_free, leak_free, trim_fire, any_free, scan_miss;
    logic [PADDR_W-1:0] old_paddr, trim_paddr;
    logic [LADDR_W-1:0] trim_laddr;

    // Decode this cycle's allocate, commit, leak and trim events
    always_comb begin
        get_fire  = bus.get_next_addr && state == READY;
        upd_fire  = bus.update_enable && pending_valid;
        old_paddr = map_paddr[bus.update_laddr];
        upd_free  = upd_fire && map_valid[bus.update_laddr];
        leak_free = get_fire && pending_valid && !upd_fire;
`ifdef REMAP_TRIM_EN
        trim_laddr = bus.trim_laddr;
        trim_fire  = bus.trim_enable && map_valid[trim_laddr] && !(upd_fire && trim_laddr == bus.update_laddr);
`else
        trim_laddr = '0;
        trim_fire  = 1'b0;
`endif
        trim_paddr = map_paddr[trim_laddr];
        any_free   = upd_free || leak_free || trim_fire;
        scan_miss  = state == SCAN && used[ptr];
    end

    // Freed pages are always distinct from each other and from the page being reserved
    always_comb begin
        used_nxt = used;
        if (leak_free) used_nxt[pending_paddr] = 1'b0;
        if (upd_free)  used_nxt[old_paddr] = 1'b0;
        if (trim_fire) used_nxt[trim_paddr] = 1'b0;
        if (get_fire)  used_nxt[ptr] = 1'b1;
        free_count_nxt = free_count + {{PADDR_W{1'b0}}, upd_free} + {{PADDR_W{1'b0}}, leak_free}
                       + {{PADDR_W{1'b0}}, trim_fire} - {{PADDR_W{1'b0}}, get_fire};
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        state <= !nRST ? SCAN : state_nxt;
    end

    // FSM next state; a free during a scan restarts the lap so FULL is never declared on a stale view
    always_comb begin
        state_nxt = state == SCAN  ? (!used[ptr] ? READY : (!any_free && scan_cnt == '1) ? FULL : SCAN) :
                    state == READY ? (get_fire ? SCAN : READY) :
                                     (any_free ? SCAN : FULL);
    end

    // FSM outputs; ptr is frozen while READY so it doubles as the offered page
    always_comb begin
        bus.addr       = ptr;
        bus.addr_valid = state == READY;
        bus.table_full = state == FULL;
        bus.free_count = free_count;
    end

    // Allocator pointer, bitmap, pending page, valid bits and commit pulse
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ptr             <= '0;
            scan_cnt        <= '0;
            used            <= '0;
            free_count      <= (PADDR_W+1)'(NPHYS);
            pending_paddr   <= '0;
            pending_valid   <= 1'b0;
            map_valid       <= '0;
            bus.update_done <= 1'b0;
        end else begin
            ptr             <= ptr + {{(PADDR_W-1){1'b0}}, scan_miss || get_fire};
            scan_cnt        <= (any_free || get_fire) ? '0 : scan_miss ? scan_cnt + 1'b1 : scan_cnt;
            used            <= used_nxt;
            free_count      <= free_count_nxt;
            pending_paddr   <= get_fire ? ptr : pending_paddr;
            pending_valid   <= get_fire ? 1'b1 : upd_fire ? 1'b0 : pending_valid;
            if (trim_fire) map_valid[trim_laddr] <= 1'b0;
            if (upd_fire)  map_valid[bus.update_laddr] <= 1'b1;
            bus.update_done <= upd_fire || trim_fire;
        end
    end

    // Map payload needs no reset: it is only ever read through map_valid
    always_ff @(posedge CLK) begin
        if (upd_fire) map_paddr[bus.update_laddr] <= pending_paddr;
    end

    // Registered lookup, sees the table as it was before this cycle's commit
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            bus.lookup_ack   <= 1'b0;
            bus.lookup_hit   <= 1'b0;
            bus.lookup_paddr <= '0;
        end else begin
            bus.lookup_ack   <= bus.lookup_en;
            bus.lookup_hit   <= bus.lookup_en && map_valid[bus.lookup_laddr];
            bus.lookup_paddr <= (bus.lookup_en && map_valid[bus.lookup_laddr]) ? map_paddr[bus.lookup_laddr] : '0;
        end
    end
endmodule

// File: tb/tb_flash_remap_table.sv
// tb_flash_remap_table: vector table plus full-table and reset sequences, lookups checked through a scoreboard queue.
module tb_flash_remap_table;
    localparam int LW = 8;
    localparam int PW = 8;
    localparam int NP = 1 << PW;
`ifdef REMAP_TRIM_EN
    localparam int NV = 13;
`else
    localparam int NV = 9;
`endif

    typedef struct {
        bit get; bit upd; bit trim; int laddr;
        int exp_addr; bit exp_done; int exp_free; bit exp_hit; int exp_paddr;
    } vec_t;
    typedef struct { bit hit; int paddr; } lk_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   total = 0;
    int   bad = 0;
    lk_t  sb[$];
    lk_t  e;
    vec_t vt[NV];

    always #5 clk = ~clk;

    flash_remap_table_if #(.LADDR_W(LW), .PADDR_W(PW)) bus ();
    flash_remap_table #(.LADDR_W(LW), .PADDR_W(PW)) dut (.CLK(clk), .nRST(nrst), .bus(bus));

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit g, bit u, bit t, int la, int ea, bit ed, int ef, bit eh, int ep);
        vec_t v;
        v.get = g; v.upd = u; v.trim = t; v.laddr = la;
        v.exp_addr = ea; v.exp_done = ed; v.exp_free = ef; v.exp_hit = eh; v.exp_paddr = ep;
        return v;
    endfunction

    // Pop one expected lookup result per ack
    always @(negedge clk) begin
        if (bus.lookup_ack) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL lookup_ack: unexpected ack with empty queue");
            end else begin
                e = sb.pop_front();
                check("lookup_hit", bus.lookup_hit, e.hit);
                check("lookup_paddr", bus.lookup_paddr, e.paddr);
            end
        end
    end

    task automatic step(bit g, bit u, bit t, int la);
        bus.get_next_addr = g;
        bus.update_enable = u;
        bus.update_laddr  = LW'(la);
`ifdef REMAP_TRIM_EN
        bus.trim_enable = t;
        bus.trim_laddr  = LW'(la);
`else
        if (t) $display("trim requested in a build without trim");
`endif
        @(negedge clk);
        bus.get_next_addr = 1'b0;
        bus.update_enable = 1'b0;
`ifdef REMAP_TRIM_EN
        bus.trim_enable = 1'b0;
`endif
    endtask

    task automatic lookup(int la, bit h, int p);
        lk_t x;
        x.hit = h;
        x.paddr = p;
        sb.push_back(x);
        bus.lookup_en = 1'b1;
        bus.lookup_laddr = LW'(la);
        @(negedge clk);
        bus.lookup_en = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.addr_valid && n < 2 * NP) begin
            @(negedge clk);
            n++;
        end
        check("wait_addr_valid", bus.addr_valid, 1);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_addr_valid", bus.addr_valid, 0);
        check("rst_addr", bus.addr, 0);
        check("rst_free_count", bus.free_count, NP);
        check("rst_table_full", bus.table_full, 0);
        check("rst_update_done", bus.update_done, 0);
        check("rst_lookup_ack", bus.lookup_ack, 0);
        check("rst_lookup_hit", bus.lookup_hit, 0);
        check("rst_lookup_paddr", bus.lookup_paddr, 0);
        nrst = 1'b1;
        @(negedge clk);
        check("rel_addr_valid", bus.addr_valid, 1);
        check("rel_addr", bus.addr, 0);
        check("rel_free_count", bus.free_count, NP);
        check("rel_table_full", bus.table_full, 0);
    endtask

    initial begin
        int n;
        //          get upd trm la  addr done free hit paddr
        vt[0] = mk(1, 0, 0, 5, 0, 0, 255, 0, 0);
        vt[1] = mk(0, 1, 0, 5, 0, 1, 255, 1, 0);
        vt[2] = mk(1, 0, 0, 5, 1, 0, 254, 1, 0);
        vt[3] = mk(0, 1, 0, 5, 0, 1, 255, 1, 1);
        vt[4] = mk(0, 1, 0, 6, 0, 0, 255, 0, 0);
        vt[5] = mk(1, 0, 0, 6, 2, 0, 254, 0, 0);
        vt[6] = mk(1, 1, 0, 6, 3, 1, 253, 1, 2);
        vt[7] = mk(1, 0, 0, 7, 4, 0, 253, 0, 0);
        vt[8] = mk(0, 1, 0, 7, 0, 1, 253, 1, 4);
`ifdef REMAP_TRIM_EN
        vt[9]  = mk(0, 0, 1, 5, 0, 1, 254, 0, 0);
        vt[10] = mk(0, 0, 1, 9, 0, 0, 254, 0, 0);
        vt[11] = mk(1, 0, 0, 6, 5, 0, 253, 1, 2);
        vt[12] = mk(0, 1, 1, 6, 0, 1, 254, 1, 5);
        bus.trim_enable = 1'b0;
        bus.trim_laddr = '0;
`endif
        bus.get_next_addr = 1'b0;
        bus.update_enable = 1'b0;
        bus.update_laddr = '0;
        bus.lookup_en = 1'b0;
        bus.lookup_laddr = '0;
        do_reset();

        for (int i = 0; i < NV; i++) begin
            if (vt[i].get) begin
                wait_ready();
                check($sformatf("v%0d_addr", i), bus.addr, vt[i].exp_addr);
            end
            step(vt[i].get, vt[i].upd, vt[i].trim, vt[i].laddr);
            check($sformatf("v%0d_update_done", i), bus.update_done, vt[i].exp_done);
            check($sformatf("v%0d_free_count", i), bus.free_count, vt[i].exp_free);
            lookup(vt[i].laddr, vt[i].exp_hit, vt[i].exp_paddr);
            check($sformatf("v%0d_done_one_cycle", i), bus.update_done, 0);
        end

        do_reset();
        for (int i = 0; i < NP - 1; i++) begin
            wait_ready();
            step(1, 0, 0, 0);
            step(0, 1, 0, i);
        end
        wait_ready();
        check("fill_last_addr", bus.addr, NP - 1);
        check("fill_free_count", bus.free_count, 1);
        step(1, 0, 0, 0);
        n = 0;
        while (!bus.table_full && n < 2 * NP) begin
            @(negedge clk);
            n++;
        end
        check("full_table_full", bus.table_full, 1);
        check("full_addr_valid", bus.addr_valid, 0);
        check("full_free_count", bus.free_count, 0);
        step(1, 0, 0, 0);
        check("full_get_ignored_free", bus.free_count, 0);
        check("full_get_ignored_full", bus.table_full, 1);
        step(0, 1, 0, 7);
        check("remap_update_done", bus.update_done, 1);
        check("remap_free_count", bus.free_count, 1);
        check("remap_table_full", bus.table_full, 0);
        wait_ready();
        check("remap_freed_addr", bus.addr, 7);
        lookup(7, 1, NP - 1);
        lookup(8, 1, 8);

        step(1, 0, 0, 0);
        repeat (20) @(negedge clk);
        check("midscan_addr_valid", bus.addr_valid, 0);
        check("midscan_free_count", bus.free_count, 0);
        do_reset();
        lookup(7, 0, 0);
        lookup(8, 0, 0);
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
